fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain_pkg.sv | 14 +
 rtl/fifo_drain_skid.sv | 53 +++++
 rtl/fifo_drain.sv | 126 ++++++++++++
 tb/tb_fifo_drain.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types for the burst drain engine.
// Holds the FSM state enum and the skid buffer depth.
package fifo_drain_pkg;

  localparam int BUF_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: 2-entry in-order buffer between FIFO and sink.
// Ports: clk, rst (async high), push/push_data in, pop in,
//        count (entries held), head (oldest entry, 0 when cleared).
module fifo_drain_skid
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       cnt;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (cnt != 2'd0);
  // A full buffer still takes a push when
  // the oldest entry leaves in the same cycle.
  assign do_push = push &&
                   (cnt != 2'd2 || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++)
        mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop)
        rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push}
                 - {1'b0, do_pop};
    end
  end

  assign count = cnt;
  assign head  = mem[rd_ptr];

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops a burst of burst_len words from a FIFO read
// port and streams them to a valid/ready sink at 1 word/cycle.
// Ports: clk, rst (async high), start/burst_len request,
//        busy/done status, fifo_rd_en/fifo_empty/fifo_rdata
//        FIFO side, out_valid/out_data/out_ready sink side.
// Option: define FIFO_DRAIN_STATS_EN to add stall_cnt[15:0],
//        a saturating count of out_valid && !out_ready cycles.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic             fifo_rd_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_rdata,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  state_e           state;
  logic [LEN_W-1:0] remaining;
  logic             inflight;
  logic [1:0]       buf_cnt;
  logic [1:0]       occ;
  logic             xfer;
  logic             accept;
  logic             last_out;

  fifo_drain_skid #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rdata),
    .pop       (xfer),
    .count     (buf_cnt),
    .head      (out_data)
  );

  assign out_valid = (buf_cnt != 2'd0);
  assign xfer      = out_valid && out_ready;
  assign accept    = (state == IDLE) && start &&
                     (burst_len != '0);

  // Credit counts the word leaving this cycle as
  // already gone; otherwise a read could only be
  // issued every other cycle once data flows.
  assign occ = buf_cnt + {1'b0, inflight}
                       - {1'b0, xfer};

  assign fifo_rd_en = (state == RUN) &&
                      !fifo_empty &&
                      (remaining != '0) &&
                      (occ < 2'(BUF_DEPTH));

  // Last word leaves now, or already left.
  assign last_out = !inflight &&
                    (buf_cnt == 2'd0 ||
                     (buf_cnt == 2'd1 && xfer));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      unique case (state)
        IDLE: begin
          if (accept) begin
            remaining <= burst_len;
            state     <= RUN;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          if (fifo_rd_en) begin
            remaining <= remaining - 1'b1;
            if (remaining == LEN_W'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_out) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_cnt <= '0;
    else if (accept)
      stall_cnt <= '0;
    else if (out_valid && !out_ready &&
             stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: scoreboard bench with a queue-based FIFO model.
// Accepted words must equal the written word stream, in order.
module tb_fifo_drain;

  localparam int WIDTH = 16;
  localparam int LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] burst_len = '0;
  logic             busy;
  logic             done;
  logic             fifo_rd_en;
  logic             fifo_empty = 1'b1;
  logic [WIDTH-1:0] fifo_rdata = '0;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready = 1'b1;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  fifo_drain #(
    .WIDTH (WIDTH),
    .LEN_W (LEN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .fifo_rd_en (fifo_rd_en),
    .fifo_empty (fifo_empty),
    .fifo_rdata (fifo_rdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d",
               name, act, exp);
    end
  endtask

  // FIFO model: registered read data, empty flag
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] wr_pend[$];
  logic [WIDTH-1:0] all_words[$];
  int total_pops = 0;
  int outstanding = 0;

  always @(posedge clk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rdata <= fq.pop_front();
      total_pops++;
      outstanding++;
    end
    while (wr_pend.size() > 0)
      fq.push_back(wr_pend.pop_front());
    fifo_empty <= (fq.size() == 0);
  end

  task automatic write_word(input logic [WIDTH-1:0] w);
    all_words.push_back(w);
    wr_pend.push_back(w);
  endtask

  // Scoreboard: indices into all_words
  int exp_q[$];
  int ptr = 0;
  int idx;
  int done_cnt = 0;
  int stalls = 0;
  int xfer_cnt = 0;
  int cyc = 0;
  int first_x = -1;
  int last_x = -1;
  logic prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data = '0;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, prev_data);
      end
      if (fifo_rd_en)
        chk("rd_en_only_busy", busy, 1);
      if (busy)
        chk("outstanding_le2", outstanding <= 2, 1);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        outstanding--;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL extra_word: got %0h, expected none",
                   out_data);
        end else begin
          idx = exp_q.pop_front();
          chk("out_data", out_data, all_words[idx]);
        end
      end
      if (done) done_cnt++;
      if (out_valid && !out_ready) stalls++;
      prev_stall = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  // out_ready modes: 0 always, 1 pattern 1,0,0,1, 2 random
  int rmode = 0;
  int pcnt = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rmode)
      1: begin
        out_ready = (pcnt % 4 == 0) || (pcnt % 4 == 3);
        pcnt++;
      end
      2: out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n, input bit acc);
    burst_len = LEN_W'(n);
    start = 1'b1;
    if (acc) begin
      for (int i = 0; i < n; i++)
        exp_q.push_back(ptr + i);
      ptr += n;
      stalls = 0;
      first_x = -1;
    end
    cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      cycles(1);
      k++;
    end
    if (done_cnt == d0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: got none in %0d cycles",
               budget);
    end
    cycles(3);
    chk("done_once", done_cnt - d0, 1);
    chk("all_delivered", exp_q.size(), 0);
    chk("idle_after", busy, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
  endtask

  task automatic check_reset_outs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
`ifdef FIFO_DRAIN_STATS_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
  endtask

  int x0;
  int k;
  int n;
  int pre;
  int d0;

  initial begin
    #1 rst = 1'b1;
    #1 check_reset_outs();
    cycles(1);
    rst = 1'b0;
    cycles(2);

    // full 8-word burst, back-to-back
    for (int w = 1; w <= 8; w++)
      write_word(WIDTH'(w));
    cycles(2);
    do_start(8, 1);
    wait_done(50);
    chk("consecutive", last_x - first_x, 7);
    chk("fifo_empty_end", fifo_empty, 1);

    // short burst leaves the rest queued
    for (int w = 1; w <= 8; w++)
      write_word(WIDTH'(w));
    cycles(2);
    do_start(3, 1);
    wait_done(50);
    chk("fifo_left", fq.size(), 5);

    // sink stalls 1,0,0,1
    rmode = 1;
    pcnt = 0;
    for (int i = 0; i < 20; i++)
      write_word(WIDTH'($urandom));
    cycles(2);
    do_start(25, 1);
    wait_done(300);
    rmode = 0;

    // FIFO runs dry mid-burst
    chk("empty_before_pause", fifo_empty, 1);
    write_word(16'h00A1);
    write_word(16'h00A2);
    cycles(2);
    do_start(5, 1);
    fork
      begin
        cycles(10);
        write_word(16'h00A3);
        write_word(16'h00A4);
        write_word(16'h00A5);
      end
      wait_done(100);
    join

    // start while busy, then zero-length start
    for (int i = 0; i < 4; i++)
      write_word(WIDTH'($urandom));
    cycles(2);
    do_start(4, 1);
    do_start(7, 0);
    do_start(2, 0);
    wait_done(100);
    chk("busy_start_no_reads", fq.size(), 0);
    write_word(16'h0B01);
    write_word(16'h0B02);
    cycles(2);
    d0 = done_cnt;
    do_start(0, 0);
    cycles(10);
    chk("len0_no_done", done_cnt - d0, 0);
    chk("len0_no_reads", fq.size(), 2);
    chk("len0_not_busy", busy, 0);

    // reset mid-burst after two transfers
    for (int i = 0; i < 6; i++)
      write_word(WIDTH'($urandom));
    cycles(2);
    do_start(8, 1);
    x0 = xfer_cnt;
    k = 0;
    while (xfer_cnt - x0 < 2 && k < 50) begin
      cycles(1);
      k++;
    end
    chk("two_xfers_before_rst", xfer_cnt - x0 >= 2, 1);
    rst = 1'b1;
    #1 check_reset_outs();
    cycles(1);
    rst = 1'b0;
    exp_q.delete();
    outstanding = 0;
    ptr = total_pops;
    cycles(2);
    do_start(1, 1);
    wait_done(30);

    // random bursts, random sink, trickled writes
    rmode = 2;
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 12);
      pre = $urandom_range(0, n);
      for (int i = 0; i < pre; i++)
        write_word(WIDTH'($urandom));
      cycles(2);
      do_start(n, 1);
      fork
        begin
          for (int i = pre; i < n; i++) begin
            cycles($urandom_range(0, 3));
            write_word(WIDTH'($urandom));
          end
        end
        wait_done(400);
      join
    end
    rmode = 0;
    cycles(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
